// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: assembles WIDTH-bit words from a qualified bit
// stream, holds one word on a valid/ready port and flags dropped words.
module sipo_deframer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             se_in,
  input  logic             bit_en,
  input  logic             sync,
  input  logic             par_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic [CW-1:0]    bit_cnt,
  output logic             ovf
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] out_r;
  logic             valid_r;
  logic             ovf_r;

  logic [WIDTH-1:0] word_s;
  logic             last_s;
  logic             complete_s;
  logic             accept_s;
  logic             load_s;
  logic             drop_s;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    logic [WIDTH-1:0] nxt;
    if (LSB_FIRST) begin
      nxt = {b, cur[WIDTH-1:1]};
    end else begin
      nxt = {cur[WIDTH-2:0], b};
    end
    return nxt;
  endfunction

  // Per-edge decode: a sync'd bit always starts a new word, so it never completes one.
  always_comb begin
    word_s     = shift_in(sh_r, se_in);
    last_s     = (cnt_r == LAST_CNT);
    complete_s = bit_en & ~sync & last_s;
    accept_s   = valid_r & par_ready;
    load_s     = complete_s & (~valid_r | accept_s);
    drop_s     = complete_s & valid_r & ~par_ready;
  end

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_r  <= '0;
      cnt_r <= '0;
    end else begin
      if (bit_en) begin
        sh_r <= word_s;
      end
      if (sync) begin
        cnt_r <= bit_en ? CW'(1'b1) : '0;
      end else if (bit_en) begin
        cnt_r <= last_s ? '0 : cnt_r + CW'(1'b1);
      end
    end
  end

  // Holding register and valid flag for the parallel handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r   <= '0;
      valid_r <= 1'b0;
    end else if (load_s) begin
      out_r   <= word_s;
      valid_r <= 1'b1;
    end else if (accept_s && !complete_s) begin
      valid_r <= 1'b0;
    end
  end

  // Sticky overflow; a drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end
  end

  assign par_out   = out_r;
  assign par_valid = valid_r;
  assign bit_cnt   = cnt_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: MSB-first and LSB-first instances share one stimulus
// stream and are scored against a bit-queue reference model.
module tb_sipo_deframer;
  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst, se_in, bit_en, sync, par_ready, ovf_clr;
  logic [W-1:0]  out_m, out_l;
  logic          valid_m, valid_l, ovf_m, ovf_l;
  logic [CW-1:0] cnt_m, cnt_l;

  sipo_deframer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .se_in(se_in), .bit_en(bit_en), .sync(sync),
    .par_ready(par_ready), .ovf_clr(ovf_clr), .par_out(out_m),
    .par_valid(valid_m), .bit_cnt(cnt_m), .ovf(ovf_m));

  sipo_deframer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .se_in(se_in), .bit_en(bit_en), .sync(sync),
    .par_ready(par_ready), .ovf_clr(ovf_clr), .par_out(out_l),
    .par_valid(valid_l), .bit_cnt(cnt_l), .ovf(ovf_l));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] m;
    logic [W-1:0] l;
  } word_t;

  word_t exp_q[$];
  bit    bits[$];
  bit    m_valid = 1'b0;
  bit    m_ovf   = 1'b0;
  bit    mon_en  = 1'b0;
  int    errors  = 0;
  int    checks  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the partial word is a queue of received bits.
  task automatic model_step();
    bit    acc, done, drop;
    word_t w;
    w = '0;
    if (rst) begin
      bits.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      acc  = m_valid && par_ready;
      done = 1'b0;
      if (bit_en) begin
        if (sync) bits.delete();
        bits.push_back(se_in);
        if (!sync && bits.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            w.m[W-1-i] = bits[i];
            w.l[i]     = bits[i];
          end
          bits.delete();
        end
      end else if (sync) begin
        bits.delete();
      end
      drop = done && m_valid && !acc;
      if (done && !drop) begin
        m_valid = 1'b1;
        exp_q.push_back(w);
      end else if (!done && acc) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  endtask

  task automatic cyc(input bit en, input bit b, input bit sy, input bit rdy, input bit clr, input bit r);
    bit_en    = en;
    se_in     = en ? b : 1'bx;
    sync      = sy;
    par_ready = rdy;
    ovf_clr   = clr;
    rst       = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy);
    for (int i = W - 1; i >= 0; i--) cyc(1'b1, w[i], 1'b0, rdy, 1'b0, 1'b0);
  endtask

  // Monitor: compares DUT state to the model and pops words as they are accepted.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid_msb", valid_m, m_valid);
      check("valid_lsb", valid_l, m_valid);
      check("cnt_msb", cnt_m, bits.size());
      check("cnt_lsb", cnt_l, bits.size());
      check("ovf_msb", ovf_m, m_ovf);
      check("ovf_lsb", ovf_l, m_ovf);
      if (m_valid) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("word_msb", out_m, exp_q[0].m);
          check("word_lsb", out_l, exp_q[0].l);
          if (par_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a5;
    logic [W-1:0] w22;
    a5  = 8'hA5;
    w22 = 8'h22;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    check("reset_valid", valid_m, 0);
    check("reset_cnt", cnt_m, 0);
    check("reset_ovf", ovf_m, 0);

    // Plan 1/2: 0xA5 on both bit orders, bit_cnt walk, one-cycle valid.
    for (int i = 0; i < W; i++) begin
      cyc(1'b1, a5[W-1-i], 1'b0, 1'b1, 1'b0, 1'b0);
      check("t1_cnt", cnt_m, (i + 1) % W);
    end
    check("t1_valid", valid_m, 1);
    check("t1_word_msb", out_m, 8'hA5);
    check("t1_word_lsb", out_l, 8'hA5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t1_valid_fall", valid_m, 0);
    send_word(8'hC0, 1'b1);
    check("t2_word_lsb", out_l, 8'h03);
    check("t2_word_msb", out_m, 8'hC0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Plan 3: back-pressure, drop, ovf clear, drain.
    send_word(8'h3C, 1'b0);
    send_word(8'hF0, 1'b0);
    check("t3_hold_word", out_m, 8'h3C);
    check("t3_hold_valid", valid_m, 1);
    check("t3_ovf_set", ovf_m, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_ovf_clr", ovf_m, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_drain", valid_m, 0);

    // Plan 4: accept and completion on the same edge.
    send_word(8'h11, 1'b0);
    for (int i = W - 1; i >= 0; i--) cyc(1'b1, w22[i], 1'b0, i == 0, 1'b0, 1'b0);
    check("t4_word", out_m, 8'h22);
    check("t4_valid", valid_m, 1);
    check("t4_ovf", ovf_m, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Plan 5: sync realignment, then reset mid-word.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_sync_cnt", cnt_m, 1);
    for (int i = 0; i < 7; i++) cyc(1'b1, i == 6, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_sync_word", out_m, 8'h81);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'h77, 1'b0);
    send_word(8'h55, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_rst_cnt", cnt_m, 0);
    check("t5_rst_valid", valid_m, 0);
    check("t5_rst_ovf", ovf_m, 0);
    send_word(8'h5A, 1'b1);
    check("t5_clean_word", out_m, 8'h5A);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 23) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
    end
    for (int n = 0; n < 4; n++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
